// File: rtl/usb_rx_line_pkg.sv
// Shared types for the USB full-speed receive line decoder.
// Line states are encoded as {dp, dm} so a raw pad pair casts directly.
package usb_rx_line_pkg;

  typedef enum logic [1:0] {
    LINE_SE0 = 2'b00,
    LINE_K   = 2'b01,
    LINE_J   = 2'b10,
    LINE_SE1 = 2'b11
  } line_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_ACTIVE,
    RX_SE0_1,
    RX_EOP_WAIT
  } rx_state_t;

  localparam int STUFF_LIMIT = 6;
  localparam int ONES_W      = $clog2(STUFF_LIMIT + 1);

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/usb_rx_line_sync.sv
// Two-flop synchroniser for one asynchronous pad line.
// RST_VAL is the idle level of the line, so reset release looks like a quiet bus.
module usb_rx_line_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic n_rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/usb_rx_line_decoder.sv
// USB full-speed RX front end: sync, edge-locked bit timer, NRZI decode, unstuff, EOP/error flags.
// Optional 3-tap majority glitch filter on each synced line: define USB_RX_LINE_GLITCH_FILTER_EN.
module usb_rx_line_decoder
  import usb_rx_line_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_POINT = 3
) (
  input  logic clk,
  input  logic n_rst,
  input  logic dplusin,
  input  logic dminusin,
  output logic bit_valid,
  output logic bit_data,
  output logic eop,
  output logic stuff_err,
  output logic line_err,
  output logic rcving
);

  localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0]     TIMER_MAX    = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0]     TIMER_SAMPLE = TW'(SAMPLE_POINT);
  localparam logic [ONES_W-1:0] STUFF_MAX    = ONES_W'(STUFF_LIMIT);
  localparam logic [1:0]        IDLE_J       = 2'b10;

  logic [1:0]        w_pad;
  logic [1:0]        w_sync;
  logic [1:0]        w_line_bits;
  logic              w_dp;
  line_state_t       w_line;
  logic              w_edge;
  logic [TW-1:0]     w_timer;
  logic              w_strobe;
  logic              w_nrzi_bit;

  logic              r_dp_last;
  logic [TW-1:0]     r_timer;
  rx_state_t         r_state;
  logic [ONES_W-1:0] r_ones_cnt;
  logic              r_prev_dp;
  logic              r_bit_valid;
  logic              r_bit_data;
  logic              r_eop;
  logic              r_stuff_err;
  logic              r_line_err;
  logic              r_rcving;

  assign w_pad = {dplusin, dminusin};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_line
      usb_rx_line_sync #(
        .RST_VAL (IDLE_J[gi])
      ) u_sync (
        .clk     (clk),
        .n_rst   (n_rst),
        .i_async (w_pad[gi]),
        .o_sync  (w_sync[gi])
      );
`ifdef USB_RX_LINE_GLITCH_FILTER_EN
      logic [1:0] r_tap;
      logic       r_filt;

      // A one-cycle pulse never wins the vote against two settled taps.
      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          r_tap  <= {2{IDLE_J[gi]}};
          r_filt <= IDLE_J[gi];
        end else begin
          r_tap  <= {r_tap[0], w_sync[gi]};
          r_filt <= maj3(w_sync[gi], r_tap[0], r_tap[1]);
        end
      end

      assign w_line_bits[gi] = r_filt;
`else
      assign w_line_bits[gi] = w_sync[gi];
`endif
    end
  endgenerate

  assign w_dp   = w_line_bits[1];
  assign w_line = line_state_t'(w_line_bits);

  // The edge cycle itself counts as timer 0 so the sample lands SAMPLE_POINT clocks later.
  assign w_edge     = w_dp ^ r_dp_last;
  assign w_timer    = w_edge ? '0 : r_timer;
  assign w_strobe   = (w_timer == TIMER_SAMPLE);
  assign w_nrzi_bit = (w_dp == r_prev_dp);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_dp_last <= 1'b1;
      r_timer   <= '0;
    end else begin
      r_dp_last <= w_dp;
      r_timer   <= (w_timer == TIMER_MAX) ? '0 : w_timer + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= RX_IDLE;
      r_ones_cnt  <= '0;
      r_prev_dp   <= 1'b1;
      r_bit_valid <= 1'b0;
      r_bit_data  <= 1'b0;
      r_eop       <= 1'b0;
      r_stuff_err <= 1'b0;
      r_line_err  <= 1'b0;
      r_rcving    <= 1'b0;
    end else begin
      r_bit_valid <= 1'b0;
      r_bit_data  <= 1'b0;
      r_eop       <= 1'b0;
      r_stuff_err <= 1'b0;
      r_line_err  <= 1'b0;
      if (w_strobe) begin
        case (r_state)
          RX_IDLE: begin
            if (w_line == LINE_K) begin
              // First K of the sync pattern decodes as 0 against the idle J.
              r_state     <= RX_ACTIVE;
              r_rcving    <= 1'b1;
              r_bit_valid <= 1'b1;
              r_bit_data  <= 1'b0;
              r_prev_dp   <= 1'b0;
              r_ones_cnt  <= '0;
            end else if (w_line == LINE_SE1) begin
              r_line_err <= 1'b1;
            end
          end

          RX_ACTIVE: begin
            case (w_line)
              LINE_J, LINE_K: begin
                if (r_ones_cnt == STUFF_MAX) begin
                  r_ones_cnt <= '0;
                  if (w_nrzi_bit) begin
                    r_stuff_err <= 1'b1;
                    r_state     <= RX_IDLE;
                    r_rcving    <= 1'b0;
                    r_prev_dp   <= 1'b1;
                  end else begin
                    r_prev_dp <= w_dp;
                  end
                end else begin
                  r_bit_valid <= 1'b1;
                  r_bit_data  <= w_nrzi_bit;
                  r_prev_dp   <= w_dp;
                  r_ones_cnt  <= w_nrzi_bit ? r_ones_cnt + 1'b1 : '0;
                end
              end
              LINE_SE0: begin
                r_state <= RX_SE0_1;
              end
              default: begin
                r_line_err <= 1'b1;
                r_state    <= RX_IDLE;
                r_rcving   <= 1'b0;
                r_ones_cnt <= '0;
                r_prev_dp  <= 1'b1;
              end
            endcase
          end

          RX_SE0_1: begin
            if (w_line == LINE_SE0) begin
              r_eop   <= 1'b1;
              r_state <= RX_EOP_WAIT;
            end else begin
              r_line_err <= 1'b1;
              r_state    <= RX_IDLE;
              r_rcving   <= 1'b0;
              r_ones_cnt <= '0;
              r_prev_dp  <= 1'b1;
            end
          end

          RX_EOP_WAIT: begin
            if (w_line == LINE_J) begin
              r_state    <= RX_IDLE;
              r_rcving   <= 1'b0;
              r_ones_cnt <= '0;
              r_prev_dp  <= 1'b1;
            end else if (w_line != LINE_SE0) begin
              r_line_err <= 1'b1;
              r_state    <= RX_IDLE;
              r_rcving   <= 1'b0;
              r_ones_cnt <= '0;
              r_prev_dp  <= 1'b1;
            end
          end

          default: begin
            r_state    <= RX_IDLE;
            r_rcving   <= 1'b0;
            r_ones_cnt <= '0;
            r_prev_dp  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bit_valid = r_bit_valid;
  assign bit_data  = r_bit_data;
  assign eop       = r_eop;
  assign stuff_err = r_stuff_err;
  assign line_err  = r_line_err;
  assign rcving    = r_rcving;

endmodule

// File: tb/tb_usb_rx_line_decoder.sv
// Table-driven bench for usb_rx_line_decoder: each row is one line symbol plus the
// decoder event it must produce; events are collected by a monitor and compared in order.
module tb_usb_rx_line_decoder;

  localparam logic [1:0] SJ  = 2'b10;
  localparam logic [1:0] SK  = 2'b01;
  localparam logic [1:0] S0  = 2'b00;
  localparam logic [1:0] S1  = 2'b11;

  localparam int EV_NONE  = 0;
  localparam int EV_B0    = 1;
  localparam int EV_B1    = 2;
  localparam int EV_EOP   = 3;
  localparam int EV_STUFF = 4;
  localparam int EV_LINE  = 5;

  typedef struct {
    logic [1:0] sym;
    int         evt;
  } vec_t;

  typedef struct {
    int   evt;
    logic rcv;
  } obs_t;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic dplusin = 1'b1;
  logic dminusin = 1'b0;
  logic bit_valid, bit_data, eop, stuff_err, line_err, rcving;

  vec_t tbl[$];
  obs_t obs[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_multi = 0;

  always #5 clk = ~clk;

  usb_rx_line_decoder dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .dplusin   (dplusin),
    .dminusin  (dminusin),
    .bit_valid (bit_valid),
    .bit_data  (bit_data),
    .eop       (eop),
    .stuff_err (stuff_err),
    .line_err  (line_err),
    .rcving    (rcving)
  );

  always @(negedge clk) begin
    int hot;
    obs_t o;
    hot = int'(bit_valid) + int'(eop) + int'(stuff_err) + int'(line_err);
    if (hot > 1) n_multi++;
    o.rcv = rcving;
    o.evt = EV_NONE;
    if (line_err)       o.evt = EV_LINE;
    else if (stuff_err) o.evt = EV_STUFF;
    else if (eop)       o.evt = EV_EOP;
    else if (bit_valid) o.evt = bit_data ? EV_B1 : EV_B0;
    if (o.evt != EV_NONE) obs.push_back(o);
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic send(input logic [1:0] s, input int cpb);
    {dplusin, dminusin} = s;
    repeat (cpb) @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [1:0] s, input int e);
    vec_t v;
    v.sym = s;
    v.evt = e;
    tbl.push_back(v);
  endtask

  task automatic add_sync();
    add(SK, EV_B0); add(SJ, EV_B0); add(SK, EV_B0); add(SJ, EV_B0);
    add(SK, EV_B0); add(SJ, EV_B0); add(SK, EV_B0); add(SK, EV_B1);
  endtask

  task automatic add_eop();
    add(S0, EV_NONE); add(S0, EV_EOP); add(SJ, EV_NONE);
  endtask

  task automatic run_table(input string name, input int cpb);
    int exp_q[$];
    int n;
    obs.delete();
    foreach (tbl[i]) begin
      send(tbl[i].sym, cpb);
      if (tbl[i].evt != EV_NONE) exp_q.push_back(tbl[i].evt);
    end
    repeat (4) send(SJ, cpb);
    check({name, " count"}, obs.size(), exp_q.size());
    n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      $display("%s ev%0d evt=%0d rcving=%0d", name, i, obs[i].evt, obs[i].rcv);
      check($sformatf("%s ev%0d", name, i), obs[i].evt, exp_q[i]);
      check($sformatf("%s rcv%0d", name, i), int'(obs[i].rcv),
            (exp_q[i] == EV_STUFF || exp_q[i] == EV_LINE) ? 0 : 1);
    end
    check({name, " rcving_end"}, int'(rcving), 0);
    tbl.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #2;
    check("reset_outs", int'({bit_valid, bit_data, eop, stuff_err, line_err, rcving}), 0);
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    // Idle J for over 100 clocks
    for (int i = 0; i < 13; i++) add(SJ, EV_NONE);
    run_table("idle", 8);

    add_sync(); add_eop();
    run_table("sync8", 8);

    // 0xFF payload: stuffed J after five payload 1s (sixth 1 counting the sync's last bit)
    add_sync();
    for (int i = 0; i < 5; i++) add(SK, EV_B1);
    add(SJ, EV_NONE);
    add(SJ, EV_B1); add(SJ, EV_B1); add(SJ, EV_B1);
    add_eop();
    run_table("stuff0", 8);

    // 0x5A payload, LSB first: 0,1,0,1,1,0,1,0
    add_sync();
    add(SJ, EV_B0); add(SJ, EV_B1); add(SK, EV_B0); add(SK, EV_B1);
    add(SK, EV_B1); add(SJ, EV_B0); add(SJ, EV_B1); add(SK, EV_B0);
    add_eop();
    run_table("pay5a", 8);

    // Seven consecutive 1s without a stuff transition
    add_sync();
    for (int i = 0; i < 5; i++) add(SK, EV_B1);
    add(SK, EV_STUFF);
    add(S0, EV_NONE); add(S0, EV_NONE); add(SJ, EV_NONE);
    run_table("stuff_err", 8);

    add_sync();
    add(S0, EV_NONE); add(SK, EV_LINE); add(SJ, EV_NONE);
    run_table("se0_k", 8);

    add(SJ, EV_NONE); add(S1, EV_LINE); add(SJ, EV_NONE);
    run_table("se1_idle", 8);

    add_sync();
    add(S1, EV_LINE); add(SJ, EV_NONE);
    run_table("se1_active", 8);

    add_sync();
    add(S0, EV_NONE); add(S0, EV_EOP); add(SK, EV_LINE); add(SJ, EV_NONE);
    run_table("eopwait_k", 8);

    add_sync();
    add(SJ, EV_B0); add(SK, EV_B0); add(SJ, EV_B0);
    add_eop();
    run_table("drift7", 7);

    add_sync();
    add(SJ, EV_B0); add(SK, EV_B0); add(SJ, EV_B0);
    add_eop();
    run_table("drift9", 9);

    // Reset asserted in the middle of a packet
    obs.delete();
    send(SK, 8); send(SJ, 8); send(SK, 8); send(SJ, 8); send(SK, 4);
    check("pre_rst_rcving", int'(rcving), 1);
    n_rst = 1'b0;
    #2;
    check("rst_async_outs", int'({bit_valid, bit_data, eop, stuff_err, line_err, rcving}), 0);
    {dplusin, dminusin} = SJ;
    repeat (3) @(posedge clk);
    #3;
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_outs", int'({bit_valid, bit_data, eop, stuff_err, line_err, rcving}), 0);
    for (int i = 0; i < 6; i++) add(SJ, EV_NONE);
    add_sync(); add_eop();
    run_table("post_rst", 8);

    check("no_overlap", n_multi, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
